lsu_issue_sequencer: RTL and testbench



---
 rtl/lsu_issue_sequencer_pkg.sv | 34 +++
 rtl/lsu_issue_stall_mon.sv | 31 +++
 rtl/lsu_issue_sequencer.sv | 145 ++++++++++++++
 tb/tb_lsu_issue_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_issue_sequencer_pkg.sv
// Shared types for the LSU issue sequencer: functional-unit codes, head-entry struct, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lsu_issue_sequencer_pkg;

  // Functional-unit code carried by every request-buffer entry
  typedef enum logic [3:0] {
    NONE      = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6,
    FPU       = 4'd7
  } fu_t;

  // Head entry of the LSU request buffer
  typedef struct packed {
    logic        valid;
    fu_t         fu;
    logic [3:0]  trans_id;
    logic [31:0] vaddr;
    logic [7:0]  be;
  } lsu_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_LD = 2'd1,
    ISSUE_ST = 2'd2,
    DRAIN    = 2'd3
  } lsu_issue_state_e;

endpackage

// File: rtl/lsu_issue_stall_mon.sv
// Counts consecutive handshake-wait cycles and flags a stall once the count reaches STALL_LIMIT.
// Latency: stall_o reflects waits up to the previous clock edge (decoded from the count register).
// Backpressure: none; observes the handshake only, the count saturates at STALL_LIMIT.
module lsu_issue_stall_mon #(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic clear_i,
  output logic stall_o
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Saturating wait counter; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (wait_i && (cnt_q != CW'(STALL_LIMIT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_o = (cnt_q >= CW'(STALL_LIMIT));

endmodule

// File: rtl/lsu_issue_sequencer.sv
// Takes the LSU request-buffer head, steers it to the load or store unit and pops the buffer on accept.
// Latency: sample -> unit valid 1 cycle; pop in the accept cycle; one drain cycle, so <= 1 request / 3 cycles.
// Backpressure: holds valid and req_o stable until ready; flush drops the request without popping.
module lsu_issue_sequencer
  import lsu_issue_sequencer_pkg::*;
#(
  parameter type         lsu_ctrl_t  = lsu_req_t,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  lsu_ctrl_t            lsu_ctrl_i,
  input  logic                 buf_empty_i,
  output logic                 ld_valid_o,
  input  logic                 ld_ready_i,
  output logic                 st_valid_o,
  input  logic                 st_ready_i,
  output lsu_ctrl_t            req_o,
  output logic                 pop_ld_o,
  output logic                 pop_st_o,
  output logic                 stall_o,
  output logic                 bad_fu_o,
  output logic [CNT_WIDTH-1:0] ld_issued_o,
  output logic [CNT_WIDTH-1:0] st_issued_o
);

  lsu_issue_state_e      state_q, state_d;
  lsu_ctrl_t             req_q, req_d;
  logic [CNT_WIDTH-1:0]  ld_cnt_q, st_cnt_q;
  logic                  head_ld, head_st, head_bad;
  logic                  ld_acc, st_acc;
  logic                  stall_wait, stall_clear;

  assign head_ld  = lsu_ctrl_i.valid && (lsu_ctrl_i.fu == LOAD);
  assign head_st  = lsu_ctrl_i.valid && (lsu_ctrl_i.fu == STORE);
  assign head_bad = lsu_ctrl_i.valid && !head_ld && !head_st;

  // A flush in the accept cycle cancels the acceptance
  assign ld_acc = (state_q == ISSUE_LD) && ld_ready_i && !flush_i;
  assign st_acc = (state_q == ISSUE_ST) && st_ready_i && !flush_i;

  // State, latched request and issue counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_q    <= '0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (ld_acc) ld_cnt_q <= ld_cnt_q + 1'b1;
      if (st_acc) st_cnt_q <= st_cnt_q + 1'b1;
    end
  end

  // Next state and request latch; flush overrides everything
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (flush_i) begin
      state_d = IDLE;
      req_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (head_ld) begin
            state_d = ISSUE_LD;
            req_d   = lsu_ctrl_i;
          end else if (head_st) begin
            state_d = ISSUE_ST;
            req_d   = lsu_ctrl_i;
          end else if (head_bad) begin
            state_d = DRAIN;
          end
        end
        ISSUE_LD: if (ld_ready_i) state_d = DRAIN;
        ISSUE_ST: if (st_ready_i) state_d = DRAIN;
        DRAIN:    state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Unit valids are Moore outputs; pops and the bad-fu pulse are same-cycle
  always_comb begin
    ld_valid_o = 1'b0;
    st_valid_o = 1'b0;
    pop_ld_o   = 1'b0;
    pop_st_o   = 1'b0;
    bad_fu_o   = 1'b0;
    case (state_q)
      IDLE: begin
        bad_fu_o = head_bad && !flush_i;
        pop_ld_o = head_bad && !flush_i;
      end
      ISSUE_LD: begin
        ld_valid_o = 1'b1;
        pop_ld_o   = ld_acc;
      end
      ISSUE_ST: begin
        st_valid_o = 1'b1;
        pop_st_o   = st_acc;
      end
      default: ;
    endcase
  end

  assign req_o       = req_q;
  assign ld_issued_o = ld_cnt_q;
  assign st_issued_o = st_cnt_q;

  assign stall_wait  = ((state_q == ISSUE_LD) && !ld_ready_i) ||
                       ((state_q == ISSUE_ST) && !st_ready_i);
  assign stall_clear = flush_i || ld_acc || st_acc ||
                       (state_q == IDLE) || (state_q == DRAIN);

  lsu_issue_stall_mon #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_mon (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wait_i (stall_wait),
    .clear_i(stall_clear),
    .stall_o(stall_o)
  );

`ifndef SYNTHESIS
  // The buffer must not report empty while its head is still owned here
  a_no_lost_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q != IDLE) && !flush_i) |-> !buf_empty_i)
    else $error("buffer reported empty with an unpopped entry in flight");

  a_pop_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_ld_o && pop_st_o))
    else $error("load and store pop in the same cycle");

  a_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ld_valid_o && st_valid_o))
    else $error("load and store valid in the same cycle");
`endif

endmodule

// File: tb/tb_lsu_issue_sequencer.sv
// Randomized and directed stimulus for lsu_issue_sequencer, checked against a transaction-level model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: ready randomized; long directed wait exercises the stall flag.
module tb_lsu_issue_sequencer;
  import lsu_issue_sequencer_pkg::*;

  localparam int unsigned LIMIT = 16;
  localparam int unsigned CW    = 4;

  logic          clk_i       = 1'b0;
  logic          rst_ni      = 1'b0;
  logic          flush_i     = 1'b0;
  logic          buf_empty_i = 1'b1;
  logic          ld_ready_i  = 1'b0;
  logic          st_ready_i  = 1'b0;
  lsu_req_t      lsu_ctrl_i  = '0;
  logic          ld_valid_o, st_valid_o, pop_ld_o, pop_st_o, stall_o, bad_fu_o;
  lsu_req_t      req_o;
  logic [CW-1:0] ld_issued_o, st_issued_o;

  int errors = 0;
  int checks = 0;

  // Model: what the sequencer currently owns, and what it has issued
  int       m_kind;   // 0 nothing held, 1 load awaiting accept, 2 store awaiting accept, 3 post-pop gap
  lsu_req_t m_req;
  int       m_ld, m_st, m_wait;

  lsu_issue_sequencer #(
    .lsu_ctrl_t (lsu_req_t),
    .STALL_LIMIT(LIMIT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .lsu_ctrl_i (lsu_ctrl_i),
    .buf_empty_i(buf_empty_i),
    .ld_valid_o (ld_valid_o),
    .ld_ready_i (ld_ready_i),
    .st_valid_o (st_valid_o),
    .st_ready_i (st_ready_i),
    .req_o      (req_o),
    .pop_ld_o   (pop_ld_o),
    .pop_st_o   (pop_st_o),
    .stall_o    (stall_o),
    .bad_fu_o   (bad_fu_o),
    .ld_issued_o(ld_issued_o),
    .st_issued_o(st_issued_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic lsu_req_t mk(input fu_t fu, input logic v);
    lsu_req_t r;
    r.valid    = v;
    r.fu       = fu;
    r.trans_id = 4'($urandom);
    r.vaddr    = $urandom;
    r.be       = 8'($urandom);
    return r;
  endfunction

  function automatic bit is_bad(input lsu_req_t h);
    return h.valid && (h.fu != LOAD) && (h.fu != STORE);
  endfunction

  task automatic model_reset();
    m_kind = 0; m_req = '0; m_ld = 0; m_st = 0; m_wait = 0;
  endtask

  task automatic check_outputs();
    bit idle_bad;
    idle_bad = (m_kind == 0) && is_bad(lsu_ctrl_i) && !flush_i;
    check_eq("ld_valid", ld_valid_o, m_kind == 1);
    check_eq("st_valid", st_valid_o, m_kind == 2);
    check_eq("pop_ld", pop_ld_o, idle_bad || ((m_kind == 1) && ld_ready_i && !flush_i));
    check_eq("pop_st", pop_st_o, (m_kind == 2) && st_ready_i && !flush_i);
    check_eq("bad_fu", bad_fu_o, idle_bad);
    check_eq("pop_excl", pop_ld_o && pop_st_o, 0);
    check_eq("stall", stall_o, m_wait >= LIMIT);
    check_eq("req", req_o, m_req);
    check_eq("ld_issued", ld_issued_o, m_ld % (1 << CW));
    check_eq("st_issued", st_issued_o, m_st % (1 << CW));
  endtask

  task automatic model_step();
    if (flush_i) begin
      m_kind = 0; m_req = '0; m_wait = 0;
    end else begin
      case (m_kind)
        0: if (lsu_ctrl_i.valid) begin
             if (lsu_ctrl_i.fu == LOAD)       begin m_kind = 1; m_req = lsu_ctrl_i; end
             else if (lsu_ctrl_i.fu == STORE) begin m_kind = 2; m_req = lsu_ctrl_i; end
             else                                   m_kind = 3;
           end
        1: if (ld_ready_i) begin m_ld++; m_kind = 3; m_wait = 0; end else m_wait++;
        2: if (st_ready_i) begin m_st++; m_kind = 3; m_wait = 0; end else m_wait++;
        default: m_kind = 0;
      endcase
    end
  endtask

  // One clock: drive, check against the model, then advance the model
  task automatic cycle(input lsu_req_t head, input logic lr, input logic sr, input logic fl);
    @(negedge clk_i);
    lsu_ctrl_i  = head;
    ld_ready_i  = lr;
    st_ready_i  = sr;
    flush_i     = fl;
    buf_empty_i = (m_kind == 0) ? !head.valid : 1'b0;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ld_valid"}, ld_valid_o, 0);
    check_eq({tag, "_st_valid"}, st_valid_o, 0);
    check_eq({tag, "_pop_ld"}, pop_ld_o, 0);
    check_eq({tag, "_pop_st"}, pop_st_o, 0);
    check_eq({tag, "_stall"}, stall_o, 0);
    check_eq({tag, "_bad_fu"}, bad_fu_o, 0);
    check_eq({tag, "_req"}, req_o, 0);
    check_eq({tag, "_ld_cnt"}, ld_issued_o, 0);
    check_eq({tag, "_st_cnt"}, st_issued_o, 0);
  endtask

  initial begin
    lsu_req_t h, inv;
    model_reset();
    inv = '0;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Load accepted on the first issue cycle
    h = mk(LOAD, 1'b1);
    cycle(h, 1'b0, 1'b0, 1'b0);
    cycle(h, 1'b1, 1'b0, 1'b0);
    cycle(inv, 1'b0, 1'b0, 1'b0);
    check_eq("ld_cnt_after_first", ld_issued_o, 1);
    cycle(inv, 1'b0, 1'b0, 1'b0);

    // Store held off for 20 cycles
    h = mk(STORE, 1'b1);
    cycle(h, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(h, 1'b1, 1'b0, 1'b0);
    check_eq("stall_after_20", stall_o, 1);
    cycle(h, 1'b0, 1'b1, 1'b0);
    cycle(inv, 1'b0, 1'b0, 1'b0);
    check_eq("stall_cleared", stall_o, 0);
    cycle(inv, 1'b0, 1'b0, 1'b0);

    // Flush coinciding with ready
    h = mk(LOAD, 1'b1);
    cycle(h, 1'b0, 1'b0, 1'b0);
    cycle(h, 1'b0, 1'b0, 1'b0);
    cycle(h, 1'b1, 1'b0, 1'b1);
    cycle(inv, 1'b1, 1'b0, 1'b0);
    check_eq("flush_ld_cnt", ld_issued_o, 1);

    // Unsupported functional unit
    cycle(mk(CSR, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(inv, 1'b1, 1'b1, 1'b0);
    cycle(inv, 1'b1, 1'b1, 1'b0);

    // Back-to-back load, store, load with ready always high
    for (int i = 0; i < 9; i++) begin
      h = mk((i / 3 == 1) ? STORE : LOAD, 1'b1);
      cycle(h, 1'b1, 1'b1, 1'b0);
    end

    // Reset in the middle of a store, then wrap the load counter
    h = mk(STORE, 1'b1);
    cycle(h, 1'b0, 1'b0, 1'b0);
    cycle(h, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni     = 1'b0;
    st_ready_i = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    lsu_ctrl_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 17; i++) begin
      h = mk(LOAD, 1'b1);
      cycle(h, 1'b0, 1'b0, 1'b0);
      cycle(h, 1'b1, 1'b0, 1'b0);
      cycle(inv, 1'b0, 1'b0, 1'b0);
    end
    check_eq("ld_cnt_wrap", ld_issued_o, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int   r;
      fu_t  f;
      r = int'($urandom_range(0, 9));
      if (r < 4)      f = LOAD;
      else if (r < 8) f = STORE;
      else            f = fu_t'($urandom_range(0, 7));
      h = mk(f, $urandom_range(0, 3) != 0);
      cycle(h, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
